// File: rtl/traffic_pkg.sv
// Shared light encoding, tracker states and default sizing for the intersection checker.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED     = 2'b00,
        YELLOW  = 2'b01,
        GREEN   = 2'b10,
        ILLEGAL = 2'b11
    } light_t;

    typedef enum logic [1:0] {
        TRK_RED    = 2'b00,
        TRK_GREEN  = 2'b01,
        TRK_YELLOW = 2'b10
    } trk_t;

    localparam int QW_DEF      = 4;
    localparam int YEL_CYC_DEF = 2;

endpackage

// File: rtl/lane_queue.sv
// One lane: car queue depth with saturation, waiting sensor, and a light-sequence tracker.
module lane_queue
    import traffic_pkg::*;
#(
    parameter int QW      = QW_DEF,
    parameter int YEL_CYC = YEL_CYC_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_light,
    input  logic          i_arrive,
    output logic [QW-1:0] o_q,
    output logic          o_sensor,
    output logic          o_overflow,
    output logic          o_seq_err
);

    localparam int YW = $clog2(YEL_CYC + 2);
    localparam logic [QW-1:0] Q_MAX   = '1;
    localparam logic [YW-1:0] Y_EXACT = YW'(YEL_CYC);

    light_t        w_light;
    logic          w_depart;
    logic [QW-1:0] r_q;
    logic          r_ovf;
    trk_t          r_trk;
    logic [YW-1:0] r_ycnt;
    logic          r_seq;

    assign w_light  = light_t'(i_light);
    assign w_depart = (w_light == GREEN) && (r_q != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else if (i_arrive && !w_depart) begin
            if (r_q == Q_MAX) r_ovf <= 1'b1;
            else              r_q   <= r_q + 1'b1;
        end else if (!i_arrive && w_depart) begin
            r_q <= r_q - 1'b1;
        end
    end

    // Tracker follows the sampled light even after an error; an illegal code holds the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_trk  <= TRK_RED;
            r_ycnt <= '0;
            r_seq  <= 1'b0;
        end else begin
            case (w_light)
                RED: begin
                    if (r_trk == TRK_GREEN) r_seq <= 1'b1;
                    if (r_trk == TRK_YELLOW && r_ycnt != Y_EXACT) r_seq <= 1'b1;
                    r_trk  <= TRK_RED;
                    r_ycnt <= '0;
                end
                GREEN: begin
                    if (r_trk == TRK_YELLOW) r_seq <= 1'b1;
                    r_trk  <= TRK_GREEN;
                    r_ycnt <= '0;
                end
                YELLOW: begin
                    if (r_trk == TRK_RED) r_seq <= 1'b1;
                    r_trk <= TRK_YELLOW;
                    if (r_trk != TRK_YELLOW) begin
                        r_ycnt <= YW'(1);
                    end else if (r_ycnt == Y_EXACT) begin
                        // Run is about to reach YEL_CYC+1: flag now, then saturate.
                        r_ycnt <= r_ycnt + 1'b1;
                        r_seq  <= 1'b1;
                    end else if (r_ycnt < Y_EXACT) begin
                        r_ycnt <= r_ycnt + 1'b1;
                    end
                end
                default: begin
                    r_trk <= r_trk;
                end
            endcase
        end
    end

    assign o_q        = r_q;
    assign o_sensor   = (r_q != '0);
    assign o_overflow = r_ovf;
    assign o_seq_err  = r_seq;

endmodule

// File: rtl/intersection_model.sv
// Three-lane intersection observer: per-lane queues/trackers plus a cross-lane conflict check.
module intersection_model
    import traffic_pkg::*;
#(
    parameter int QW      = QW_DEF,
    parameter int YEL_CYC = YEL_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    ew_str_light,
    input  logic [1:0]    ew_left_light,
    input  logic [1:0]    ns_light,
    input  logic          ew_str_arrive,
    input  logic          ew_left_arrive,
    input  logic          ns_arrive,
    output logic          ew_str_sensor,
    output logic          ew_left_sensor,
    output logic          ns_sensor,
    output logic [QW-1:0] ew_str_q,
    output logic [QW-1:0] ew_left_q,
    output logic [QW-1:0] ns_q,
    output logic          overflow_err,
    output logic          conflict_err,
    output logic          seq_err
);

    logic [2:0] w_ovf;
    logic [2:0] w_seq;
    logic [1:0] w_nonred_cnt;
    logic       w_illegal;
    logic       w_conflict;
    logic       r_conflict;

    lane_queue #(.QW(QW), .YEL_CYC(YEL_CYC)) u_ew_str (
        .i_clk(clk), .i_rst(reset), .i_light(ew_str_light), .i_arrive(ew_str_arrive),
        .o_q(ew_str_q), .o_sensor(ew_str_sensor), .o_overflow(w_ovf[0]), .o_seq_err(w_seq[0])
    );

    lane_queue #(.QW(QW), .YEL_CYC(YEL_CYC)) u_ew_left (
        .i_clk(clk), .i_rst(reset), .i_light(ew_left_light), .i_arrive(ew_left_arrive),
        .o_q(ew_left_q), .o_sensor(ew_left_sensor), .o_overflow(w_ovf[1]), .o_seq_err(w_seq[1])
    );

    lane_queue #(.QW(QW), .YEL_CYC(YEL_CYC)) u_ns (
        .i_clk(clk), .i_rst(reset), .i_light(ns_light), .i_arrive(ns_arrive),
        .o_q(ns_q), .o_sensor(ns_sensor), .o_overflow(w_ovf[2]), .o_seq_err(w_seq[2])
    );

    // An illegal code also counts as non-red; either condition alone is a conflict.
    assign w_nonred_cnt = {1'b0, |ew_str_light} + {1'b0, |ew_left_light} + {1'b0, |ns_light};
    assign w_illegal    = (&ew_str_light) | (&ew_left_light) | (&ns_light);
    assign w_conflict   = w_illegal | (w_nonred_cnt > 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_conflict <= 1'b0;
        else if (w_conflict) r_conflict <= 1'b1;
    end

    assign overflow_err = |w_ovf;
    assign seq_err      = |w_seq;
    assign conflict_err = r_conflict;

endmodule
